video_timing_gen: RTL

- Parametrised raster timing generator; successor to the fixed 384x262 generator.
- Produces the pixel/line counters, blanking, sync, line/frame strobes and a raster-line interrupt for the video pipeline and CPU.
- Geometry is set by parameters; sync position is trimmed at runtime by signed offsets applied only at frame boundaries.
- All logic runs in the clk domain, gated by a pixel clock enable.

---
 rtl/video_timing_gen_if.sv | 37 +++
 rtl/video_timing_gen.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/video_timing_gen_if.sv
// Raster timing bundle shared by video_timing_gen and its consumers.
// master : the side that drives pixel enable, offsets and interrupt control
//          (the CPU/video pipeline), and reads counters and timing flags.
// slave  : the timing generator itself.
// Signals:
//   ce_pix, hs_offset, vs_offset, irq_line, irq_en, irq_ack  master -> slave
//   hc, vc, hbl, vbl, hsync, vsync, line_start, frame_start,
//   raster_irq                                                slave -> master
interface video_timing_gen_if #(
  parameter int CW = 9
);
  logic                 ce_pix;
  logic signed [CW-1:0] hs_offset;
  logic signed [CW-1:0] vs_offset;
  logic        [CW-1:0] irq_line;
  logic                 irq_en;
  logic                 irq_ack;
  logic        [CW-1:0] hc;
  logic        [CW-1:0] vc;
  logic                 hbl;
  logic                 vbl;
  logic                 hsync;
  logic                 vsync;
  logic                 line_start;
  logic                 frame_start;
  logic                 raster_irq;

  modport master (
    output ce_pix, hs_offset, vs_offset, irq_line, irq_en, irq_ack,
    input  hc, vc, hbl, vbl, hsync, vsync, line_start, frame_start, raster_irq
  );

  modport slave (
    input  ce_pix, hs_offset, vs_offset, irq_line, irq_en, irq_ack,
    output hc, vc, hbl, vbl, hsync, vsync, line_start, frame_start, raster_irq
  );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator.
// Produces pixel/line counters, blanking, sync windows (trimmed by signed
// offsets latched at frame boundaries), line/frame strobes and a level
// raster interrupt. Everything advances only on ce_pix, except reset and
// irq_ack which act on any clk edge.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   vif    video_timing_gen_if.slave (see interface for signal list)
module video_timing_gen #(
  parameter int CW         = 9,
  parameter int H_TOTAL    = 384,
  parameter int H_ACTIVE   = 256,
  parameter int HS_START   = 264,
  parameter int HS_END     = 296,
  parameter int V_TOTAL    = 262,
  parameter int V_BL_END   = 16,
  parameter int V_BL_START = 240,
  parameter int VS_START   = 244,
  parameter int VS_END     = 248,
  parameter int OFS_MAX    = 32,
  parameter int IRQ_HPOS   = 0
) (
  input logic              clk,
  input logic              reset,
  video_timing_gen_if.slave vif
);

  localparam logic [CW-1:0] P_H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] P_V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] P_H_ACTIVE   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] P_V_BL_END   = CW'(V_BL_END);
  localparam logic [CW-1:0] P_V_BL_START = CW'(V_BL_START);
  localparam logic [CW-1:0] P_IRQ_HPOS   = CW'(IRQ_HPOS);

  localparam logic signed [CW:0] P_H_TOTAL  = (CW+1)'(H_TOTAL);
  localparam logic signed [CW:0] P_V_TOTAL  = (CW+1)'(V_TOTAL);
  localparam logic signed [CW:0] P_HS_START = (CW+1)'(HS_START);
  localparam logic signed [CW:0] P_HS_END   = (CW+1)'(HS_END);
  localparam logic signed [CW:0] P_VS_START = (CW+1)'(VS_START);
  localparam logic signed [CW:0] P_VS_END   = (CW+1)'(VS_END);
  localparam logic signed [CW:0] P_OFS_MAX  = (CW+1)'(OFS_MAX);
  localparam logic signed [CW:0] P_OFS_MIN  = -P_OFS_MAX;

  logic [CW-1:0]        r_hc, r_vc;
  logic signed [CW:0]   r_ho, r_vo;
  logic                 r_hbl, r_vbl, r_hsync, r_vsync;
  logic                 r_line_start, r_frame_start, r_irq;

  logic                 w_h_wrap, w_frame_wrap, w_irq_set;
  logic [CW-1:0]        w_hc_nxt, w_vc_nxt;
  logic signed [CW:0]   w_ho, w_vo;
  logic [CW-1:0]        w_hs_beg, w_hs_end, w_vs_beg, w_vs_end;

  function automatic logic signed [CW:0] clamp_ofs(input logic signed [CW-1:0] v);
    logic signed [CW:0] ext;
    ext = {v[CW-1], v};
    if (ext > P_OFS_MAX)      return P_OFS_MAX;
    else if (ext < P_OFS_MIN) return P_OFS_MIN;
    else                      return ext;
  endfunction

  // Offsets are bounded by OFS_MAX, so one add or subtract of the period
  // is enough to bring a trimmed edge back into range.
  function automatic logic [CW-1:0] wrap_mod(input logic signed [CW:0] v,
                                             input logic signed [CW:0] total);
    logic signed [CW:0] r;
    if (v < 0)           r = v + total;
    else if (v >= total) r = v - total;
    else                 r = v;
    return r[CW-1:0];
  endfunction

  // beg > fin means the window straddles the counter wrap.
  function automatic logic in_window(input logic [CW-1:0] pos,
                                     input logic [CW-1:0] beg,
                                     input logic [CW-1:0] fin);
    if (beg <= fin) return (pos >= beg) && (pos < fin);
    else            return (pos >= beg) || (pos < fin);
  endfunction

  assign w_h_wrap     = (r_hc == P_H_LAST);
  assign w_hc_nxt     = w_h_wrap ? '0 : r_hc + CW'(1);
  assign w_vc_nxt     = !w_h_wrap ? r_vc :
                        (r_vc == P_V_LAST) ? '0 : r_vc + CW'(1);
  assign w_frame_wrap = (w_hc_nxt == '0) && (w_vc_nxt == '0);

  // The frame being entered already uses the offsets sampled on this edge.
  assign w_ho = w_frame_wrap ? clamp_ofs(vif.hs_offset) : r_ho;
  assign w_vo = w_frame_wrap ? clamp_ofs(vif.vs_offset) : r_vo;

  assign w_hs_beg = wrap_mod(P_HS_START + w_ho, P_H_TOTAL);
  assign w_hs_end = wrap_mod(P_HS_END   + w_ho, P_H_TOTAL);
  assign w_vs_beg = wrap_mod(P_VS_START + w_vo, P_V_TOTAL);
  assign w_vs_end = wrap_mod(P_VS_END   + w_vo, P_V_TOTAL);

  assign w_irq_set = vif.ce_pix && vif.irq_en &&
                     (w_hc_nxt == P_IRQ_HPOS) && (w_vc_nxt == vif.irq_line);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hc          <= '0;
      r_vc          <= '0;
      r_ho          <= '0;
      r_vo          <= '0;
      r_hbl         <= 1'b0;
      r_vbl         <= 1'b1;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_irq         <= 1'b0;
    end else begin
      if (vif.ce_pix) begin
        r_hc          <= w_hc_nxt;
        r_vc          <= w_vc_nxt;
        r_ho          <= w_ho;
        r_vo          <= w_vo;
        r_hbl         <= (w_hc_nxt >= P_H_ACTIVE);
        r_vbl         <= (w_vc_nxt < P_V_BL_END) || (w_vc_nxt >= P_V_BL_START);
        r_hsync       <= in_window(w_hc_nxt, w_hs_beg, w_hs_end);
        r_vsync       <= in_window(w_vc_nxt, w_vs_beg, w_vs_end);
        r_line_start  <= (w_hc_nxt == '0);
        r_frame_start <= w_frame_wrap;
      end
      if (w_irq_set)        r_irq <= 1'b1;
      else if (vif.irq_ack) r_irq <= 1'b0;
    end
  end

  assign vif.hc          = r_hc;
  assign vif.vc          = r_vc;
  assign vif.hbl         = r_hbl;
  assign vif.vbl         = r_vbl;
  assign vif.hsync       = r_hsync;
  assign vif.vsync       = r_vsync;
  assign vif.line_start  = r_line_start;
  assign vif.frame_start = r_frame_start;
  assign vif.raster_irq  = r_irq;

endmodule
